// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and constants for the ASCII serializer
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_TICK_DIV = 25000000;
  localparam logic [7:0] ASCII_E = 8'h45;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_TICK_DIV);

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen
  import serializer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  output logic tick
);

  localparam int W = cnt_width(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  // With TICK_DIV=1 the counter sits at 0 and tick stays high every cycle.
  assign tick = (count == LAST);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ascii_serializer.sv
// rtl/ascii_serializer.sv - one-deep buffered MSB-first bit serializer paced by tick_gen
module ascii_serializer
  import serializer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [7:0] char_in,
  input  logic       char_load,
  output logic       char_ready,
  output logic       ser_bit,
  output logic       bit_valid,
  output logic       char_done,
  output logic       busy,
  output logic [2:0] bit_idx
);

  state_t     state;
  logic [7:0] hold;
  logic       hold_valid;
  logic [7:0] shift;
  logic       tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .tick    (tick)
  );

  assign char_ready = !hold_valid;

  // Accept and hold-transfer are mutually exclusive on hold_valid, so a load
  // coinciding with a transfer is simply not accepted that cycle.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      ser_bit    <= 1'b0;
      bit_valid  <= 1'b0;
      char_done  <= 1'b0;
      busy       <= 1'b0;
      bit_idx    <= 3'd7;
    end else begin
      bit_valid <= 1'b0;
      char_done <= 1'b0;

      if (char_load && !hold_valid) begin
        hold       <= char_in;
        hold_valid <= 1'b1;
      end

      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (hold_valid) begin
              shift      <= hold;
              hold_valid <= 1'b0;
              bit_idx    <= 3'd7;
              state      <= ST_SHIFT;
              busy       <= 1'b1;
            end
          end
          ST_SHIFT: begin
            ser_bit   <= shift[7];
            bit_valid <= 1'b1;
            if (bit_idx == 3'd0) begin
              char_done <= 1'b1;
              bit_idx   <= 3'd7;
              if (hold_valid) begin
                shift      <= hold;
                hold_valid <= 1'b0;
              end else begin
                shift <= {shift[6:0], 1'b0};
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              shift   <= {shift[6:0], 1'b0};
              bit_idx <= bit_idx - 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_serializer.sv
// tb/tb_ascii_serializer.sv - scoreboard bench for ascii_serializer at TICK_DIV=4 and TICK_DIV=1
module tb_ascii_serializer;
  import serializer_pkg::*;

  typedef struct {
    logic b;
    logic done;
    logic gap;
    logic lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  logic [7:0] char_in, char_in1;
  logic       char_load, char_load1;
  logic       char_ready, ser_bit, bit_valid, char_done, busy;
  logic [2:0] bit_idx;
  logic       char_ready1, ser_bit1, bit_valid1, char_done1, busy1;
  logic [2:0] bit_idx1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc4 = 0, acc1 = 0;
  int   last4 = 0, last1 = 0;
  int   det_hits = 0;
  int   hits0;
  logic [7:0] det = 8'h00;
  exp_t q4[$];
  exp_t q1[$];

  ascii_serializer #(.TICK_DIV(4)) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .char_in   (char_in),
    .char_load (char_load),
    .char_ready(char_ready),
    .ser_bit   (ser_bit),
    .bit_valid (bit_valid),
    .char_done (char_done),
    .busy      (busy),
    .bit_idx   (bit_idx)
  );

  ascii_serializer #(.TICK_DIV(1)) dut1 (
    .CLOCK_50  (clk),
    .RST_N     (rst1_n),
    .char_in   (char_in1),
    .char_load (char_load1),
    .char_ready(char_ready1),
    .ser_bit   (ser_bit1),
    .bit_valid (bit_valid1),
    .char_done (char_done1),
    .busy      (busy1),
    .bit_idx   (bit_idx1)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor for the TICK_DIV=4 instance, plus a behavioural E-pattern detector.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      det = 8'h00;
    end else begin
      if (char_done && !bit_valid) chk("done_without_strobe", 1, 0);
      if (bit_valid) begin
        det = {det[6:0], ser_bit};
        if (det == ASCII_E) det_hits++;
        if (q4.size() == 0) begin
          chk("unexpected_strobe4", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("ser_bit4", ser_bit, e.b);
          chk("char_done4", char_done, e.done);
          if (e.gap) chk("gap4", cyc - last4, 4);
        end
        last4 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst1_n && bit_valid1) begin
      if (q1.size() == 0) begin
        chk("unexpected_strobe1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("ser_bit1", ser_bit1, e.b);
        chk("char_done1", char_done1, e.done);
        if (e.gap) chk("gap1", cyc - last1, 1);
        if (e.lat) chk("latency1", cyc - acc1, 2);
      end
      last1 = cyc;
    end
  end

  task automatic push_char(input int sel, input logic [7:0] c, input logic gap_first, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b    = c[7-i];
      e.done = (i == 7);
      e.gap  = (i == 0) ? gap_first : 1'b1;
      e.lat  = (sel == 1) && (i == 0);
      if (sel == 0) q4.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic load4(input logic [7:0] c);
    @(negedge clk);
    char_in   = c;
    char_load = 1'b1;
    @(negedge clk);
    char_load = 1'b0;
    acc4      = cyc;
  endtask

  task automatic load1(input logic [7:0] c);
    @(negedge clk);
    char_in1   = c;
    char_load1 = 1'b1;
    @(negedge clk);
    char_load1 = 1'b0;
    acc1       = cyc;
  endtask

  task automatic wait_q4(input int budget);
    int n = 0;
    while (q4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("q4_drain", q4.size(), 0);
    q4.delete();
  endtask

  task automatic wait_q1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("q1_drain", q1.size(), 0);
    q1.delete();
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", busy, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ser_bit"}, ser_bit, 0);
    chk({tag, "_bit_valid"}, bit_valid, 0);
    chk({tag, "_char_done"}, char_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bit_idx"}, bit_idx, 7);
    chk({tag, "_char_ready"}, char_ready, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    rst1_n     = 1'b0;
    char_in    = 8'h00;
    char_load  = 1'b0;
    char_in1   = 8'h00;
    char_load1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0x45 from idle
    hits0 = det_hits;
    push_char(0, 8'h45, 1'b0, 8);
    load4(8'h45);
    wait_q4(100);
    repeat (6) @(negedge clk);
    chk("t1_busy_low", busy, 0);
    chk("t1_bit_idx", bit_idx, 7);
    chk("t1_char_ready", char_ready, 1);
    chk("t1_det_hits", det_hits - hits0, 1);

    // Back-to-back 0x45, 0x41 with an ignored 0xFF while hold is full
    hits0 = det_hits;
    push_char(0, 8'h45, 1'b0, 8);
    push_char(0, 8'h41, 1'b1, 8);
    load4(8'h45);
    wait_busy(20);
    load4(8'h41);
    chk("t2_ready_full", char_ready, 0);
    @(negedge clk);
    char_in   = 8'hFF;
    char_load = 1'b1;
    @(negedge clk);
    char_load = 1'b0;
    chk("t3_ready_after_ff", char_ready, 0);
    wait_q4(200);
    repeat (8) @(negedge clk);
    chk("t2_busy_low", busy, 0);
    chk("t2_det_hits", det_hits - hits0, 1);

    // Reset after the 3rd strobe with a character also held
    push_char(0, 8'h45, 1'b0, 3);
    load4(8'h45);
    wait_busy(20);
    load4(8'h41);
    wait_q4(60);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready", char_ready, 1);

    // TICK_DIV=1 instance
    push_char(1, 8'h45, 1'b0, 8);
    load1(8'h45);
    wait_q1(40);
    repeat (3) @(negedge clk);
    chk("t5_busy_low", busy1, 0);
    chk("t5_bit_idx", bit_idx1, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascii_serializer.md
ASCII_SERIALIZER -- requirements
Module: ascii_serializer

Interface
REQ-001 Parameter: TICK_DIV, default 25000000, sets the number of CLOCK_50 cycles per serial bit (legal range 1..2^26).
REQ-002 Port: CLOCK_50  input  1  single clock; all state is updated on its rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: char_in  input  8  ASCII character to transmit.
REQ-005 Port: char_load  input  1  request to accept char_in this cycle.
REQ-006 Port: char_ready  output  1  holding register empty; char_load is honoured only while this is high.
REQ-007 Port: ser_bit  output  1  serial data bit, MSB first; feeds the downstream bit-pattern detector.
REQ-008 Port: bit_valid  output  1  one-cycle strobe marking a new ser_bit value; serves as the detector's advance strobe.
REQ-009 Port: char_done  output  1  one-cycle pulse, coincident with the bit_valid of bit 0 of a character.
REQ-010 Port: busy  output  1  high while in SHIFT.
REQ-011 Port: bit_idx  output  3  index of the next bit to be emitted (7 down to 0); 7 when IDLE.

Function
REQ-012 Tick generator: counter runs 0..TICK_DIV-1 and wraps; tick is high for one cycle when count == TICK_DIV-1; TICK_DIV=1 gives a tick every cycle.
REQ-013 Holding register: one entry with hold_valid; char_ready = !hold_valid (combinational).
REQ-014 Accept: char_load && char_ready captures char_in into hold and sets hold_valid on that edge; char_load while char_ready=0 is ignored, and the character is dropped with no error flag.
REQ-015 FSM states: IDLE, SHIFT (2 states, encoding per package).
REQ-016 IDLE: on tick with hold_valid=1, copy hold to shift register, clear hold_valid, bit_idx=7, go to SHIFT; no bit is emitted on this tick.
REQ-017 SHIFT: on each tick, ser_bit <= shift[7], shift <= shift<<1, bit_valid=1 for that cycle, and bit_idx decrements.
REQ-018 SHIFT, tick emitting bit 0: char_done=1; if hold_valid=1, reload shift from hold, clear hold_valid, set bit_idx=7, and stay in SHIFT (back-to-back, no idle tick); otherwise go to IDLE with bit_idx=7.
REQ-019 Simultaneous events: when a hold transfer and char_load fall in the same cycle, the load is not accepted (char_ready was 0); a new character is accepted from the next cycle.
REQ-020 Between ticks: ser_bit holds its last emitted value; bit_valid and char_done are 0.
REQ-021 Bit cadence: exactly 8 bit_valid strobes per character, spaced exactly TICK_DIV cycles apart.
REQ-022 Latency: the first bit_valid of a character accepted in IDLE occurs on the second tick after acceptance.

Reset
REQ-023 RST_N low asynchronously forces: state=IDLE, tick counter=0, hold_valid=0, shift=0, ser_bit=0, bit_valid=0, char_done=0, busy=0, bit_idx=7, char_ready=1.
REQ-024 Reset mid-character discards the partial character and the held character; no char_done is produced for either.
REQ-025 After release, the first tick occurs TICK_DIV cycles after the first active edge.

Structure
REQ-026 Package serializer_pkg holds: the FSM state type/encodings, the default TICK_DIV, the counter width derived from TICK_DIV, and the constant ASCII_E = 8'h45.
REQ-027 Tick generation is a separate sub-module, tick_gen (parameter TICK_DIV; ports CLOCK_50, RST_N, tick).

Verification (run with TICK_DIV=4 unless stated)
REQ-028 Load 0x45 in IDLE -> ser_bit at the 8 bit_valid strobes = 0,1,0,0,0,1,0,1; char_done on the 8th strobe; busy falls afterwards; a detector model flags exactly once.
REQ-029 Load 0x45, then load 0x41 while shifting -> 16 consecutive strobes, 4 cycles apart, with no gap; 2nd byte = 0,1,0,0,0,0,0,1; two char_done pulses.
REQ-030 With hold full, pulse char_load with 0xFF -> char_ready=0, the load is ignored, and 0xFF never appears on ser_bit.
REQ-031 Assert RST_N low after the 3rd strobe of 0x45 -> all outputs at reset values immediately; no further strobes until a new load.
REQ-032 TICK_DIV=1, load 0x45 -> strobes on 8 consecutive cycles starting 2 cycles after acceptance, with the same bit sequence.
